// File: rtl/reg_bank_if.sv
// ============================================================================
//  Module   : reg_bank_if
//  Purpose  : Control, data and flag signals shared between bus master and reg_bank.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic [WIDTH-1:0]  bus_in;
    logic              low_i_en;
    logic              low_o_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        op;
    logic              zero;
    logic              carry;

    modport master (
        output bus_in, low_i_en, low_o_en, wr_addr, rd_addr, op,
        input  zero, carry
    );

    modport slave (
        input  bus_in, low_i_en, low_o_en, wr_addr, rd_addr, op,
        output zero, carry
    );
endinterface

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
//  Module   : reg_bank
//  Purpose  : DEPTH x WIDTH register bank on a tristate bus with in-place
//             inc/dec/clear and registered zero/carry flags.
//             Optional macro REG_BANK_BYPASS_EN forwards the write result
//             to bus_out on a same-address read/write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank #(
    parameter int   WIDTH  = 8,
    parameter int   DEPTH  = 4,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  wire              clk,
    input  wire              low_reset,
    reg_bank_if.slave        bus,
    output wire [WIDTH-1:0]  bus_out
);

    localparam logic [1:0]        c_op_load = 2'b00;
    localparam logic [1:0]        c_op_inc  = 2'b01;
    localparam logic [1:0]        c_op_dec  = 2'b10;
    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_zero;
    logic             r_carry;

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [WIDTH-1:0] w_stored;
    logic [WIDTH-1:0] w_rd_val;

    // Address checks only matter when DEPTH is not a power of two.
    assign w_wr_ok  = ({1'b0, bus.wr_addr} < c_depth);
    assign w_rd_ok  = ({1'b0, bus.rd_addr} < c_depth);
    assign w_cur    = w_wr_ok ? r_regs[bus.wr_addr] : '0;
    assign w_stored = w_rd_ok ? r_regs[bus.rd_addr] : '0;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (bus.op)
            c_op_load: w_res = bus.bus_in;
            c_op_inc: begin
                w_res   = w_cur + 1'b1;
                w_carry = &w_cur;
            end
            c_op_dec: begin
                w_res   = w_cur - 1'b1;
                w_carry = ~|w_cur;
            end
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!low_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else if (!bus.low_i_en && w_wr_ok) begin
            r_regs[bus.wr_addr] <= w_res;
            r_zero              <= (w_res == '0);
            r_carry             <= w_carry;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    // Same-address transfer: the reader sees this cycle's write result; reset forwards 0.
    always_comb begin
        w_rd_val = w_stored;
        if (!bus.low_i_en && w_wr_ok && (bus.rd_addr == bus.wr_addr)) begin
            w_rd_val = low_reset ? w_res : '0;
        end
    end
`else
    assign w_rd_val = w_stored;
`endif

    assign bus_out   = bus.low_o_en ? {WIDTH{1'bz}} : w_rd_val;
    assign bus.zero  = r_zero;
    assign bus.carry = r_carry;

endmodule

`default_nettype wire

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised successor to the single 8-bit bus register.
- Holds DEPTH registers of WIDTH bits, all sharing the processor bus.
- Active-low load and output enables keep the same semantics as the 8-bit register. Reads drive the tristate bus.
- Adds addressed read/write, in-place increment/decrement/clear, and registered zero/carry flags, so SAP-2 style B/C/temp registers and counters live in one block.

Parameters:
- WIDTH, 8, data width of each register and of the bus.
- DEPTH, 4, number of registers; must be ≥2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- low_reset  input  1  synchronous reset, active-low
- bus_in  input  WIDTH  data from bus, used by load op
- bus_out  output  WIDTH  tristate bus driver
- low_i_en  input  1  active-low write enable
- low_o_en  input  1  active-low bus output enable
- wr_addr  input  ADDR_W  target register for write/op
- rd_addr  input  ADDR_W  register driven onto bus
- op  input  2  00 load, 01 increment, 10 decrement, 11 clear
- zero  output  1  registered: last write result == 0
- carry  output  1  registered: carry (inc) / borrow (dec) of last write

Behaviour:
- Reset:
  - Reset is synchronous, active-low.
  - On a clk rising edge with low_reset=0: all registers become 0, zero=1, carry=0.
  - Reset overrides low_i_en and op.
  - Reset has no effect between edges.
  - bus_out stays governed by low_o_en during reset; it drives 0 from the edge onward if enabled.
- Write (low_i_en=0 at rising edge, low_reset=1): regs[wr_addr] receives a result R according to op:
  - 00: R=bus_in; carry←0.
  - 01: R=regs[wr_addr]+1 mod 2^WIDTH; carry←1 only on wrap from all-ones to 0.
  - 10: R=regs[wr_addr]-1 mod 2^WIDTH; carry←1 only on wrap from 0 to all-ones.
  - 11: R=0; carry←0.
  - zero←(R==0) in every case.
- Latency:
  - New register and flag values are visible one cycle after the edge.
  - Non-addressed registers and flags hold their values.
- low_i_en=1: no register or flag changes; op and wr_addr are ignored.
- Read:
  - Combinational: bus_out = regs[rd_addr] while low_o_en=0, else all-Z.
  - Other outputs never go Z.
- Simultaneous read/write of the same address (without bypass): bus_out shows the pre-edge value until the edge, then the new value.
- Out-of-range addresses (DEPTH not a power of two):
  - A write is dropped and flags are unchanged.
  - A read drives 0 when enabled.
- No internal state machine beyond storage and flags. The bus protocol is level-based, with no handshake.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined:
  - When low_i_en=0, low_o_en=0 and rd_addr==wr_addr, bus_out shows the would-be write result R combinationally in the same cycle.
  - This applies to all four ops, and gives single-cycle bus transfer into and out of the same register.
  - Reset still wins: while low_reset=0, bypass forwards 0.
- Not defined: reads always return stored contents.
- Flags are identical in both builds.

Test Plan:
1. Reset path: low_reset=0 for one edge, then low_o_en=0 with rd_addr 0..3 → bus_out=00 for every register, zero=1, carry=0. With low_o_en=1 → bus_out=ZZ.
2. Load and read isolation:
   - Load AA to reg1 and 55 to reg2.
   - Read reg1 → AA; read reg2 → 55; reg0 and reg3 stay 00.
   - low_i_en=1 with bus_in=FF for 3 cycles → all values unchanged.
3. Increment wrap:
   - Load FF to reg3, then op=01 → reg3=00, zero=1, carry=1.
   - op=01 again → reg3=01, zero=0, carry=0.
4. Decrement borrow and clear:
   - reg0=00, op=10 → FF, carry=1, zero=0.
   - op=11 on reg0 → 00, zero=1, carry=0.
5. Mid-operation reset:
   - low_i_en=0, op=01 on reg2 (value 7F) with low_reset=0 on the same edge → reg2=00 (not 80), zero=1.
   - Next edge with reset released → increment resumes giving 01.
6. Same-address read/write:
   - reg1=10, low_i_en=0, low_o_en=0, op=01, rd=wr=1 → bus_out=10 before the edge and 11 after.
   - With REG_BANK_BYPASS_EN defined → bus_out=11 before the edge.
